// File: rtl/bp_lce_req_queued.sv
// Buffered LCE request issuer: in-order request queue, credit-gated issue onto the coherence network.
// Optional BP_LCE_REQ_QUEUED_STATS_EN adds stat_issued_o / stat_stall_o counters.

package bp_lce_req_queued_pkg;
  localparam int unsigned paddr_width_gp  = 40;
  localparam int unsigned dword_width_gp  = 64;
  localparam int unsigned lce_id_width_gp = 4;
  localparam int unsigned cce_id_width_gp = 4;
  localparam int unsigned way_id_width_gp = 4;

  localparam logic [3:0] e_miss_load  = 4'd0;
  localparam logic [3:0] e_miss_store = 4'd1;
  localparam logic [3:0] e_uc_load    = 4'd2;
  localparam logic [3:0] e_uc_store   = 4'd3;

  localparam logic [2:0] e_lce_req_type_rd    = 3'd0;
  localparam logic [2:0] e_lce_req_type_wr    = 3'd1;
  localparam logic [2:0] e_lce_req_type_uc_rd = 3'd2;
  localparam logic [2:0] e_lce_req_type_uc_wr = 3'd3;

  typedef struct packed {
    logic [dword_width_gp-1:0] data;
    logic [2:0]                size;
    logic [paddr_width_gp-1:0] addr;
    logic [3:0]                msg_type;
  } cache_req_s;

  typedef struct packed {
    logic [way_id_width_gp-1:0] repl_way;
  } cache_req_metadata_s;

  typedef struct packed {
    cache_req_s          req;
    cache_req_metadata_s meta;
    logic                meta_v;
  } entry_s;

  typedef struct packed {
    logic [dword_width_gp-1:0]  data;
    logic                       non_excl;
    logic [way_id_width_gp-1:0] lru_way_id;
    logic [cce_id_width_gp-1:0] dst_id;
    logic [lce_id_width_gp-1:0] src_id;
    logic [2:0]                 size;
    logic [paddr_width_gp-1:0]  addr;
    logic [2:0]                 msg_type;
  } lce_req_msg_s;
endpackage

module bp_lce_req_queued
  import bp_lce_req_queued_pkg::*;
#(
  parameter int unsigned assoc_p          = 8,
  parameter int unsigned sets_p           = 64,
  parameter int unsigned block_width_p    = 512,
  parameter int unsigned fill_width_p     = block_width_p,
  parameter int unsigned req_els_p        = 4,
  parameter int unsigned credits_p        = 4,
  parameter bit          non_excl_reads_p = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
`ifdef BP_LCE_REQ_QUEUED_STATS_EN
  output logic [31:0]                stat_issued_o,
  output logic [31:0]                stat_stall_o,
`endif
  input  logic [lce_id_width_gp-1:0] lce_id_i,
  output logic                       ready_o,
  input  cache_req_s                 cache_req_i,
  input  logic                       cache_req_v_i,
  input  cache_req_metadata_s        cache_req_metadata_i,
  input  logic                       cache_req_metadata_v_i,
  input  logic                       cache_req_complete_i,
  input  logic                       uc_store_req_complete_i,
  output logic                       credits_full_o,
  output logic                       credits_empty_o,
  output lce_req_msg_s               lce_req_o,
  output logic                       lce_req_v_o,
  input  logic                       lce_req_ready_i
);

  localparam int unsigned ptr_width_lp    = $clog2(req_els_p);
  localparam int unsigned cnt_width_lp    = $clog2(req_els_p + 1);
  localparam int unsigned credit_width_lp = $clog2(credits_p + 1);
  localparam int unsigned credit_ext_lp   = credit_width_lp + 1;
  localparam int unsigned block_offset_lp = $clog2(block_width_p / 8);
  localparam logic [2:0]  block_size_lp   = 3'(block_offset_lp);

  if (assoc_p < 2 || assoc_p > (1 << way_id_width_gp) || sets_p < 1 || fill_width_p < 64
      || block_width_p < 64 || block_width_p > 1024 || req_els_p < 2 || credits_p < 1) begin : g_cfg_error
    $error("bp_lce_req_queued: unsupported configuration");
  end

  typedef enum logic {e_reset, e_run} state_e;

  state_e                     state_r;
  entry_s                     mem [req_els_p];
  entry_s                     head;
  lce_req_msg_s               msg;
  logic [ptr_width_lp-1:0]    rptr_r, wptr_r, last_ptr_r, meta_ptr;
  logic [cnt_width_lp-1:0]    cnt_r;
  logic [credit_width_lp-1:0] credit_r;
  logic [credit_ext_lp-1:0]   credit_up, credit_next;
  logic [1:0]                 credit_dn;
  logic                       running, full, head_v, enq, issue;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(req_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // Queue status, issue decision and credit arithmetic.
  always_comb begin
    running         = (state_r == e_run);
    full            = (cnt_r == cnt_width_lp'(req_els_p));
    head_v          = (cnt_r != '0);
    head            = mem[rptr_r];
    ready_o         = running & ~full;
    enq             = cache_req_v_i & ready_o & (cache_req_i.msg_type[3:2] == 2'b00);
    issue           = running & head_v & head.meta_v
                    & (credit_r < credit_width_lp'(credits_p)) & lce_req_ready_i;
    lce_req_v_o     = issue;
    meta_ptr        = enq ? wptr_r : last_ptr_r;
    credit_up       = credit_ext_lp'(credit_r) + credit_ext_lp'(issue);
    credit_dn       = 2'(cache_req_complete_i) + 2'(uc_store_req_complete_i);
    credit_next     = (credit_ext_lp'(credit_dn) > credit_up) ? '0
                    : credit_up - credit_ext_lp'(credit_dn);
    credits_full_o  = (credit_r == credit_width_lp'(credits_p));
    credits_empty_o = (credit_r == '0);
  end

  // Head entry to BedRock request; dst CCE is the address bits just above the block offset.
  always_comb begin
    msg        = '0;
    msg.addr   = head.req.addr;
    msg.src_id = lce_id_i;
    msg.dst_id = head.req.addr[block_offset_lp +: cce_id_width_gp];
    case (head.req.msg_type)
      e_miss_load: begin
        msg.msg_type   = e_lce_req_type_rd;
        msg.size       = block_size_lp;
        msg.lru_way_id = head.meta.repl_way;
        msg.non_excl   = non_excl_reads_p;
      end
      e_miss_store: begin
        msg.msg_type   = e_lce_req_type_wr;
        msg.size       = block_size_lp;
        msg.lru_way_id = head.meta.repl_way;
      end
      e_uc_load: begin
        msg.msg_type = e_lce_req_type_uc_rd;
        msg.size     = head.req.size;
      end
      e_uc_store: begin
        msg.msg_type = e_lce_req_type_uc_wr;
        msg.size     = head.req.size;
        msg.data     = head.req.data;
      end
      default: ;
    endcase
    lce_req_o = msg;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_reset;
      rptr_r     <= '0;
      wptr_r     <= '0;
      last_ptr_r <= '0;
      cnt_r      <= '0;
      credit_r   <= '0;
    end else begin
      state_r <= e_run;
      if (enq) begin
        wptr_r     <= ptr_inc(wptr_r);
        last_ptr_r <= wptr_r;
      end
      if (issue) rptr_r <= ptr_inc(rptr_r);
      cnt_r    <= cnt_r + cnt_width_lp'(enq) - cnt_width_lp'(issue);
      credit_r <= credit_width_lp'(credit_next);
    end
  end

  // Entry storage; metadata written after the enqueue so it wins for a same-cycle pair.
  always_ff @(posedge clk_i) begin
    if (~reset_i) begin
      if (enq) begin
        mem[wptr_r].req    <= cache_req_i;
        mem[wptr_r].meta   <= '0;
        mem[wptr_r].meta_v <= cache_req_i.msg_type[1];
      end
      if (cache_req_metadata_v_i) begin
        mem[meta_ptr].meta   <= cache_req_metadata_i;
        mem[meta_ptr].meta_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (~reset_i) begin
      a_credit_underflow: assert (credit_ext_lp'(credit_dn) <= credit_up)
        else $error("bp_lce_req_queued: credit return with no outstanding request");
    end
  end

`ifdef BP_LCE_REQ_QUEUED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_issued_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      if (issue) stat_issued_o <= stat_issued_o + 32'd1;
      if (running & head_v & ~issue) stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule
